// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver, common-anode, active-low outputs.
// Latches codes and a blank mask, decodes hex or keypad legends, and scans digits with dead time.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 64,
    parameter int MAP_MODE     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                  frame_tick
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             cnt;
    logic [4*NUM_DIGITS-1:0]   sh_codes;
    logic [NUM_DIGITS-1:0]     sh_blank;

    logic                      wrap;
    logic                      last_digit;
    logic                      guard;
    logic [3:0]                cur_code;
    logic                      cur_blank;
    logic [6:0]                glyph;
    logic [6:0]                seg_d;
    logic [NUM_DIGITS-1:0]     an_d;

    // Plain hexadecimal glyphs, segments {a..g}, active low.
    function automatic logic [6:0] hex_glyph(input logic [3:0] c);
        logic [6:0] g;
        unique case (c)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Keypad legend glyphs; code is {row, col} of the pressed key.
    function automatic logic [6:0] key_glyph(input logic [3:0] c);
        logic [6:0] g;
        unique case (c)
            4'h0: g = 7'b1001111; // 1
            4'h1: g = 7'b0010010; // 2
            4'h2: g = 7'b0000110; // 3
            4'h3: g = 7'b0001000; // A
            4'h4: g = 7'b1001100; // 4
            4'h5: g = 7'b0100100; // 5
            4'h6: g = 7'b0100000; // 6
            4'h7: g = 7'b1100000; // b
            4'h8: g = 7'b0001111; // 7
            4'h9: g = 7'b0000000; // 8
            4'hA: g = 7'b0000100; // 9
            4'hB: g = 7'b0110001; // C
            4'hC: g = 7'b1001000; // *
            4'hD: g = 7'b0000001; // 0
            4'hE: g = 7'b1111110; // #
            default: g = 7'b1000010; // d
        endcase
        return g;
    endfunction

    assign wrap       = (cnt == CNT_LAST);
    assign last_digit = (digit_idx == IDX_LAST);

    // Shadow registers; the display stays dark until the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_codes <= '0;
            sh_blank <= '1;
        end else if (load) begin
            sh_codes <= codes;
            sh_blank <= blank_mask;
        end
    end

    // Slot counter and digit pointer; a frame ends when the last digit's slot wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap && last_digit;
            if (wrap) begin
                cnt <= '0;
                if (last_digit) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Select the current digit's code, apply dead time and blanking, build next outputs.
    always_comb begin
        cur_code  = 4'h0;
        cur_blank = 1'b1;
        seg_d     = 7'b1111111;
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_code  = sh_codes[4*i +: 4];
                cur_blank = sh_blank[i];
            end
        end
        guard = (cnt < GUARD_END);
        glyph = (MAP_MODE != 0) ? key_glyph(cur_code) : hex_glyph(cur_code);
        if (!guard && !cur_blank) begin
            seg_d = glyph;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (digit_idx != IW'(i));
            end
        end
    end

    // Registered pin drivers; they trail the counter by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: four configurations against a cycle-count reference model.
// Directed legend, blanking and reset checks, then randomized loads and resets.
module tb_seg7_scan_driver;

    localparam int NI = 4;
    localparam int PN[NI] = '{4, 4, 1, 8};
    localparam int PR[NI] = '{8, 8, 5, 6};
    localparam int PG[NI] = '{2, 2, 1, 3};
    localparam int PM[NI] = '{0, 1, 1, 0};

    logic clk;
    logic rst_n;
    logic        ld[NI];
    logic [31:0] cd[NI];
    logic [7:0]  bm[NI];

    logic [6:0] sg[NI];
    logic [3:0] an0, an1;
    logic [0:0] an2;
    logic [7:0] an3;
    logic [1:0] ix0, ix1;
    logic [0:0] ix2;
    logic [2:0] ix3;
    logic       ft[NI];

    int vectors;
    int miscompares;

    int          ke[NI];
    logic [31:0] mc[NI];
    logic [7:0]  mb[NI];
    logic [6:0]  es[NI];
    logic [7:0]  ea[NI];
    int          ei[NI];
    logic        ef[NI];

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .MAP_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .load(ld[0]), .codes(cd[0][15:0]),
        .blank_mask(bm[0][3:0]), .seg(sg[0]), .an(an0), .digit_idx(ix0),
        .frame_tick(ft[0]));
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .MAP_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load(ld[1]), .codes(cd[1][15:0]),
        .blank_mask(bm[1][3:0]), .seg(sg[1]), .an(an1), .digit_idx(ix1),
        .frame_tick(ft[1]));
    seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(5), .GUARD_CYCLES(1), .MAP_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .load(ld[2]), .codes(cd[2][3:0]),
        .blank_mask(bm[2][0:0]), .seg(sg[2]), .an(an2), .digit_idx(ix2),
        .frame_tick(ft[2]));
    seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(6), .GUARD_CYCLES(3), .MAP_MODE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .load(ld[3]), .codes(cd[3]),
        .blank_mask(bm[3]), .seg(sg[3]), .an(an3), .digit_idx(ix3),
        .frame_tick(ft[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] an_of(int i);
        case (i)
            0: return {4'hF, an0};
            1: return {4'hF, an1};
            2: return {7'h7F, an2};
            default: return an3;
        endcase
    endfunction

    function automatic int idx_of(int i);
        case (i)
            0: return int'(ix0);
            1: return int'(ix1);
            2: return int'(ix2);
            default: return int'(ix3);
        endcase
    endfunction

    function automatic logic [6:0] hexg(int v);
        logic [6:0] t[16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[v];
    endfunction

    // Keypad legend: 0..15 are hex glyphs, 16 is '*', 17 is '#'.
    function automatic logic [6:0] glyph(int m, logic [3:0] c);
        int leg[16];
        int l;
        leg = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 16, 0, 17, 13};
        if (m == 0) return hexg(int'(c));
        l = leg[int'(c)];
        if (l == 16) return 7'b1001000;
        if (l == 17) return 7'b1111110;
        return hexg(l);
    endfunction

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, got, exp);
        end
    endtask

    // Reference model advanced per edge from elapsed slot arithmetic, plus per-cycle compare.
    always begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                ke[i] = 0;
                mc[i] = '0;
                mb[i] = 8'hFF;
                es[i] = 7'h7F;
                ea[i] = 8'hFF;
                ei[i] = 0;
                ef[i] = 1'b0;
            end else begin
                int c;
                int d;
                c = ke[i] % PR[i];
                d = (ke[i] / PR[i]) % PN[i];
                es[i] = 7'h7F;
                ea[i] = 8'hFF;
                if (c >= PG[i] && !mb[i][d]) begin
                    es[i] = glyph(PM[i], mc[i][4*d +: 4]);
                    ea[i][d] = 1'b0;
                end
                ke[i] = ke[i] + 1;
                ef[i] = (ke[i] % (PR[i] * PN[i])) == 0;
                ei[i] = (ke[i] / PR[i]) % PN[i];
                if (ld[i]) begin
                    mc[i] = cd[i];
                    mb[i] = bm[i];
                end
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("seg", i, 32'(sg[i]), 32'(es[i]));
            chk("an", i, 32'(an_of(i)), 32'(ea[i]));
            chk("digit_idx", i, 32'(idx_of(i)), 32'(ei[i]));
            chk("frame_tick", i, 32'(ft[i]), 32'(ef[i]));
            chk("an_onehot", i, 32'($countones(~an_of(i)) <= 1), 32'd1);
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ld[i] = 1'b0;
            cd[i] = '0;
            bm[i] = '0;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        ld[0] = 1'b1; cd[0] = 32'h3210; bm[0] = 8'h00;
        ld[1] = 1'b1; cd[1] = 32'hFEC3; bm[1] = 8'h00;
        @(negedge clk);
        ld[0] = 1'b0;
        ld[1] = 1'b0;
        chk("lit_guard_an", 0, 32'(an0), 32'hF);
        repeat (2) @(negedge clk);
        chk("lit_d0_an", 0, 32'(an0), 32'hE);
        chk("lit_d0_seg", 0, 32'(sg[0]), 32'b0000001);
        chk("lit_key_A", 1, 32'(sg[1]), 32'b0001000);
        repeat (8) @(negedge clk);
        chk("lit_d1_an", 0, 32'(an0), 32'hD);
        chk("lit_d1_seg", 0, 32'(sg[0]), 32'b1001111);
        chk("lit_key_star", 1, 32'(sg[1]), 32'b1001000);
        repeat (8) @(negedge clk);
        chk("lit_d2_an", 0, 32'(an0), 32'hB);
        chk("lit_d2_seg", 0, 32'(sg[0]), 32'b0010010);
        chk("lit_key_hash", 1, 32'(sg[1]), 32'b1111110);
        repeat (8) @(negedge clk);
        chk("lit_d3_an", 0, 32'(an0), 32'h7);
        chk("lit_d3_seg", 0, 32'(sg[0]), 32'b0000110);
        chk("lit_key_d", 1, 32'(sg[1]), 32'b1000010);
        repeat (4) @(negedge clk);
        chk("lit_tick_low", 0, 32'(ft[0]), 32'd0);
        @(negedge clk);
        chk("lit_tick_high", 0, 32'(ft[0]), 32'd1);
        repeat (19) @(negedge clk);
        chk("lit_pre_blank_an", 0, 32'(an0), 32'hB);
        ld[0] = 1'b1; bm[0] = 8'h04;
        @(negedge clk);
        ld[0] = 1'b0;
        @(negedge clk);
        chk("lit_blank_an", 0, 32'(an0), 32'hF);
        chk("lit_blank_seg", 0, 32'(sg[0]), 32'h7F);
        repeat (11) @(negedge clk);
        chk("lit_tick_after_blank", 0, 32'(ft[0]), 32'd1);
        ld[0] = 1'b1; bm[0] = 8'h00;
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("lit_pre_reset_an", 0, 32'(an0), 32'hB);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_async_an", 0, 32'(an0), 32'hF);
        chk("lit_async_seg", 0, 32'(sg[0]), 32'h7F);
        chk("lit_async_idx", 0, 32'(ix0), 32'd0);
        ld[0] = 1'b1; cd[0] = 32'h5555; bm[0] = 8'h00;
        repeat (2) @(negedge clk);
        ld[0] = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("lit_dark_after_reset", 0, 32'(an0), 32'hF);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                ld[i] = ($urandom_range(0, 7) == 0);
                if (ld[i]) begin
                    cd[i] = $urandom;
                    bm[i] = 8'($urandom & $urandom);
                end
            end
            if (c == 1500 || c == 2400) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) ld[i] = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
- Latches a packed vector of 4-bit codes, decodes each one to a glyph, and scans the digits one at a time.
- Decodes either as plain hex or as matrix-keypad legends (row/column code to 1-9, 0, A-D, *, #).
- Sits between the keypad scanner/debouncer and the board pins; a per-slot ghosting guard and per-digit blanking are built in.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be at least GUARD_CYCLES+1.
- GUARD_CYCLES, 64: cycles at the start of each slot during which all anodes are off (dead time).
- MAP_MODE, 1: 0 = hex glyphs 0-F; 1 = keypad legend map.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe that captures codes and blank_mask
- codes  in  4*NUM_DIGITS  packed codes; digit i uses bits [4i+3:4i]; digit 0 is rightmost
- blank_mask  in  NUM_DIGITS  1 = digit i is dark
- seg  out  7  segments {a,b,c,d,e,f,g}, active low, registered
- an  out  NUM_DIGITS  anodes, active low, one-hot-cold, registered
- digit_idx  out  $clog2(NUM_DIGITS) (minimum 1)  digit currently in its slot
- frame_tick  out  1  one-cycle pulse when digit NUM_DIGITS-1 ends its slot

Behaviour:
- Reset state (asynchronous, rst_n=0):
  - seg=7'b1111111, an all ones, digit_idx=0, frame_tick=0.
  - Shadow codes are cleared to 0; shadow blank mask is set to all ones, so the display is dark until the first load.
  - Slot counter is cleared to 0.
- Load:
  - load=1 at edge n updates the shadow registers at edge n.
  - Output uses the new values from the edge n+1 registered update onward.
  - Load during a slot takes effect mid-slot with no restart of the counter.
  - Load during a reset assertion is ignored.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On wrap, digit_idx increments modulo NUM_DIGITS.
  - If NUM_DIGITS=1, digit_idx stays 0.
- frame_tick: asserted for exactly one cycle on the counter wrap where digit_idx goes NUM_DIGITS-1 -> 0.
- Output registration:
  - Guard phase (counter < GUARD_CYCLES): an all ones, seg=7'b1111111.
  - Active phase: an[digit_idx]=0 and all other anodes are 1; seg = glyph(shadow code of digit_idx).
  - If blank_mask for that digit is 1, an stays all ones and seg stays all ones.
  - Output registers lag the counter by 1 cycle; this lag is fixed.
- Glyph table (a..g bits, active low):
  - Hex digits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Hex letters: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- MAP_MODE=1:
  - Code = {row[1:0], col[1:0]}.
  - Row 0: 1, 2, 3, A. Row 1: 4, 5, 6, b. Row 2: 7, 8, 9, C. Row 3: *, 0, #, d.
  - '*' = 1001000 (H-like); '#' = 1111110 (g only).
- MAP_MODE=0: code n displays hex digit n.
- Anodes are never driven with more than one bit low; a bench assertion checks this every cycle.

Test Plan:
- Reset dark: hold rst_n=0 for 5 cycles, release, no load, REFRESH_DIV=8, GUARD_CYCLES=2, run 100 cycles -> an=4'b1111 and seg=7'b1111111 throughout; frame_tick pulses every 32 cycles.
- Hex scan: MAP_MODE=0, load codes=16'h3210, blank_mask=0 -> per slot, an cycles through 1110, 1101, 1011, 0111 with seg 0000001, 1001111, 0010010, 0000110; an=1111 for the first 2 cycles of each slot (plus the 1-cycle lag).
- Keypad map: MAP_MODE=1, load codes={4'hF,4'hE,4'hC,4'h3} -> digit 0 shows A (0001000), digit 1 shows * (1001000), digit 2 shows # (1111110), digit 3 shows d (1000010).
- Blanking and mid-slot load: during digit 2's active phase, load blank_mask=4'b0100 -> one cycle later an=1111 and seg=1111111; the slot counter is not disturbed and frame_tick timing is unchanged.
- Asynchronous reset mid-scan: drop rst_n between clock edges while an=1011 -> an=1111 and seg=1111111 immediately (before the next edge); after release, digit_idx=0 and the display stays dark until a new load.
- Width sweep: NUM_DIGITS=1 and NUM_DIGITS=8 -> digit_idx stays 0 or wraps 7 -> 0 respectively; frame_tick period is REFRESH_DIV*NUM_DIGITS cycles; the one-hot-cold anode assertion holds.
